// File: rtl/vuop_seq_pkg.sv
// Shared definitions for the vector micro-op sequencer.
// Holds the datapath geometry, the FSM state type, the per-lane micro-op
// payload struct handed to the vector execution stage, the shared micro-op
// info struct, and the helper that turns a vector length into the index of
// the last micro-op.
package vuop_seq_pkg;

    localparam int VECTOR_REGISTERS   = 32;
    localparam int VECTOR_LANES       = 8;
    localparam int DATA_WIDTH         = 32;
    localparam int VECTOR_TICKET_BITS = 5;
    localparam int MAX_LMUL           = 8;
    localparam int VL_WIDTH           = $clog2(VECTOR_LANES * MAX_LMUL) + 1;

    localparam int REG_W   = $clog2(VECTOR_REGISTERS);
    localparam int IDX_W   = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;
    localparam int MASK_W  = VECTOR_LANES * MAX_LMUL;
    localparam int LANE_DW = VECTOR_LANES * DATA_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Per-lane payload, laid out the way the execution stage consumes it.
    typedef struct packed {
        logic [LANE_DW-1:0]      data1;
        logic [LANE_DW-1:0]      data2;
        logic [VECTOR_LANES-1:0] lane_valid;
        logic [VECTOR_LANES-1:0] lane_mask;
    } uop_t;

    // Information shared by all lanes of one micro-op.
    typedef struct packed {
        logic [REG_W-1:0]              dst;
        logic [VECTOR_TICKET_BITS-1:0] ticket;
        logic [5:0]                    funct6;
        logic [2:0]                    funct3;
        logic [VL_WIDTH-1:0]           vl;
        logic                          is_rdc;
        logic                          head_uop;
        logic                          end_uop;
    } uop_info_t;

    // vl==0 still produces one micro-op so the ticket retires; vl beyond
    // the architectural maximum is clamped to MAX_LMUL micro-ops.
    function automatic logic [IDX_W-1:0] last_uop_idx(input logic [VL_WIDTH-1:0] vl);
        int n;
        n = (int'(vl) + VECTOR_LANES - 1) / VECTOR_LANES;
        if (n < 1) n = 1;
        if (n > MAX_LMUL) n = MAX_LMUL;
        return IDX_W'(n - 1);
    endfunction

endpackage

// File: rtl/vuop_seq.sv
// Vector micro-op sequencer.
// Takes one decoded vector instruction at a time, splits it into
// ceil(vl/VECTOR_LANES) micro-ops (at least one), reads both operands from
// the vector register file for each micro-op and emits one registered
// micro-op per issue cycle. Only hold_i from the scoreboard stalls issue.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid_i/ready_o    instruction handshake
//   dst_i, src1_i, src2_i    base registers of the instruction
//   scalar_i, use_scalar_i   scalar operand replacing src2 data
//   vm_i, mask_bits_i        unmasked flag and v0 mask bitmap
//   funct6_i, funct3_i       operation select
//   vl_i, ticket_i, is_rdc_i vector length, ticket, reduction flag
//   hold_i                   scoreboard stall
//   rf_addr_a/b_o            register file read addresses (combinational)
//   rf_data_a/b_i            register file read data (same cycle)
//   valid_o ... end_uop_o    registered micro-op to the execution stage
//   idle_o                   no instruction held and no micro-op on output
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no instruction held; ready to accept
// ST_ISSUE | instruction latched; issuing micro-op idx each unheld cycle
module vuop_seq
    import vuop_seq_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    input  logic [REG_W-1:0]              dst_i,
    input  logic [REG_W-1:0]              src1_i,
    input  logic [REG_W-1:0]              src2_i,
    input  logic [DATA_WIDTH-1:0]         scalar_i,
    input  logic                          use_scalar_i,
    input  logic                          vm_i,
    input  logic [MASK_W-1:0]             mask_bits_i,
    input  logic [5:0]                    funct6_i,
    input  logic [2:0]                    funct3_i,
    input  logic [VL_WIDTH-1:0]           vl_i,
    input  logic [VECTOR_TICKET_BITS-1:0] ticket_i,
    input  logic                          is_rdc_i,
    input  logic                          hold_i,
    output logic [REG_W-1:0]              rf_addr_a_o,
    output logic [REG_W-1:0]              rf_addr_b_o,
    input  logic [LANE_DW-1:0]            rf_data_a_i,
    input  logic [LANE_DW-1:0]            rf_data_b_i,
    output logic                          valid_o,
    output logic [VECTOR_LANES-1:0]       lane_valid_o,
    output logic [VECTOR_LANES-1:0]       lane_mask_o,
    output logic [LANE_DW-1:0]            data1_o,
    output logic [LANE_DW-1:0]            data2_o,
    output logic [REG_W-1:0]              uop_dst_o,
    output logic [VECTOR_TICKET_BITS-1:0] uop_ticket_o,
    output logic [5:0]                    uop_funct6_o,
    output logic [2:0]                    uop_funct3_o,
    output logic [VL_WIDTH-1:0]           uop_vl_o,
    output logic                          uop_is_rdc_o,
    output logic                          head_uop_o,
    output logic                          end_uop_o,
    output logic                          idle_o
);

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, last_q;

    // Latched instruction
    logic [REG_W-1:0]              dst_q, src1_q, src2_q;
    logic [DATA_WIDTH-1:0]         scalar_q;
    logic                          use_scalar_q, vm_q, is_rdc_q;
    logic [MAX_LMUL-1:0][VECTOR_LANES-1:0] mask_q;
    logic [5:0]                    funct6_q;
    logic [2:0]                    funct3_q;
    logic [VL_WIDTH-1:0]           vl_q;
    logic [VECTOR_TICKET_BITS-1:0] ticket_q;

    // Output register
    logic      valid_q;
    uop_t      uop_q, uop_d;
    uop_info_t info_q, info_d;

    logic issue, at_last, accept;
    logic [VECTOR_LANES-1:0] lane_valid_d;

    assign at_last = (idx_q == last_q);
    assign accept  = instr_valid_i && instr_ready_o;

    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        issue         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                issue = !hold_i;
                // Accepting on the last issue cycle keeps back-to-back
                // instructions bubble-free.
                if (!hold_i && at_last) begin
                    instr_ready_o = 1'b1;
                    state_d       = instr_valid_i ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register offsets wrap naturally because VECTOR_REGISTERS is a power of two.
    assign rf_addr_a_o = src1_q + REG_W'(idx_q);
    assign rf_addr_b_o = src2_q + REG_W'(idx_q);

    for (genvar k = 0; k < VECTOR_LANES; k++) begin : g_lane
        assign lane_valid_d[k] = (int'(idx_q) * VECTOR_LANES + k) < int'(vl_q);
    end

    always_comb begin
        uop_d.data1      = rf_data_a_i;
        uop_d.data2      = use_scalar_q ? {VECTOR_LANES{scalar_q}} : rf_data_b_i;
        uop_d.lane_valid = lane_valid_d;
        uop_d.lane_mask  = vm_q ? {VECTOR_LANES{1'b1}} : mask_q[idx_q];

        info_d.dst      = dst_q + REG_W'(idx_q);
        info_d.ticket   = ticket_q;
        info_d.funct6   = funct6_q;
        info_d.funct3   = funct3_q;
        info_d.vl       = vl_q;
        info_d.is_rdc   = is_rdc_q;
        info_d.head_uop = (idx_q == '0);
        info_d.end_uop  = at_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            valid_q      <= 1'b0;
            uop_q        <= '0;
            info_q       <= '0;
            dst_q        <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            scalar_q     <= '0;
            use_scalar_q <= 1'b0;
            vm_q         <= 1'b0;
            is_rdc_q     <= 1'b0;
            mask_q       <= '0;
            funct6_q     <= '0;
            funct3_q     <= '0;
            vl_q         <= '0;
            ticket_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= issue;
            if (issue) begin
                uop_q  <= uop_d;
                info_q <= info_d;
                idx_q  <= idx_q + IDX_W'(1);
            end
            // A same-cycle accept overrides the index advance above.
            if (accept) begin
                idx_q        <= '0;
                last_q       <= last_uop_idx(vl_i);
                dst_q        <= dst_i;
                src1_q       <= src1_i;
                src2_q       <= src2_i;
                scalar_q     <= scalar_i;
                use_scalar_q <= use_scalar_i;
                vm_q         <= vm_i;
                is_rdc_q     <= is_rdc_i;
                mask_q       <= mask_bits_i;
                funct6_q     <= funct6_i;
                funct3_q     <= funct3_i;
                vl_q         <= vl_i;
                ticket_q     <= ticket_i;
            end
        end
    end

    assign valid_o      = valid_q;
    assign lane_valid_o = uop_q.lane_valid;
    assign lane_mask_o  = uop_q.lane_mask;
    assign data1_o      = uop_q.data1;
    assign data2_o      = uop_q.data2;
    assign uop_dst_o    = info_q.dst;
    assign uop_ticket_o = info_q.ticket;
    assign uop_funct6_o = info_q.funct6;
    assign uop_funct3_o = info_q.funct3;
    assign uop_vl_o     = info_q.vl;
    assign uop_is_rdc_o = info_q.is_rdc;
    assign head_uop_o   = info_q.head_uop;
    assign end_uop_o    = info_q.end_uop;
    assign idle_o       = (state_q == ST_IDLE) && !valid_q;

endmodule

// File: tb/tb_vuop_seq.sv
// Self-checking bench for vuop_seq: directed scenarios followed by random
// instructions with random scoreboard holds, checked against a queue of
// expected micro-ops computed from the instruction fields.
module tb_vuop_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid_i, instr_ready_o;
    logic [4:0]   dst_i, src1_i, src2_i;
    logic [31:0]  scalar_i;
    logic         use_scalar_i, vm_i;
    logic [63:0]  mask_bits_i;
    logic [5:0]   funct6_i;
    logic [2:0]   funct3_i;
    logic [6:0]   vl_i;
    logic [4:0]   ticket_i;
    logic         is_rdc_i, hold_i;
    logic [4:0]   rf_addr_a_o, rf_addr_b_o;
    logic [255:0] rf_data_a_i, rf_data_b_i;
    logic         valid_o;
    logic [7:0]   lane_valid_o, lane_mask_o;
    logic [255:0] data1_o, data2_o;
    logic [4:0]   uop_dst_o, uop_ticket_o;
    logic [5:0]   uop_funct6_o;
    logic [2:0]   uop_funct3_o;
    logic [6:0]   uop_vl_o;
    logic         uop_is_rdc_o, head_uop_o, end_uop_o, idle_o;

    always #5 clk = ~clk;

    vuop_seq dut (
        .clk(clk), .rst(rst),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .dst_i(dst_i), .src1_i(src1_i), .src2_i(src2_i),
        .scalar_i(scalar_i), .use_scalar_i(use_scalar_i), .vm_i(vm_i),
        .mask_bits_i(mask_bits_i), .funct6_i(funct6_i), .funct3_i(funct3_i),
        .vl_i(vl_i), .ticket_i(ticket_i), .is_rdc_i(is_rdc_i), .hold_i(hold_i),
        .rf_addr_a_o(rf_addr_a_o), .rf_addr_b_o(rf_addr_b_o),
        .rf_data_a_i(rf_data_a_i), .rf_data_b_i(rf_data_b_i),
        .valid_o(valid_o), .lane_valid_o(lane_valid_o), .lane_mask_o(lane_mask_o),
        .data1_o(data1_o), .data2_o(data2_o), .uop_dst_o(uop_dst_o),
        .uop_ticket_o(uop_ticket_o), .uop_funct6_o(uop_funct6_o),
        .uop_funct3_o(uop_funct3_o), .uop_vl_o(uop_vl_o),
        .uop_is_rdc_o(uop_is_rdc_o), .head_uop_o(head_uop_o),
        .end_uop_o(end_uop_o), .idle_o(idle_o)
    );

    logic [255:0] rf_mem [32];
    assign rf_data_a_i = rf_mem[rf_addr_a_o];
    assign rf_data_b_i = rf_mem[rf_addr_b_o];

    typedef struct {
        logic [4:0]  dst, src1, src2;
        logic [31:0] scalar;
        logic        use_scalar, vm;
        logic [63:0] mask;
        logic [5:0]  f6;
        logic [2:0]  f3;
        logic [6:0]  vl;
        logic [4:0]  tkt;
        logic        rdc;
    } ins_t;

    typedef struct {
        logic [255:0] d1, d2;
        logic [7:0]   lv, lm;
        logic [4:0]   dst;
        logic         head, last;
        logic [21:0]  info;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   hold_pct = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ins_t def_ins();
        ins_t i;
        i.dst = 5'd12; i.src1 = 5'd4; i.src2 = 5'd8;
        i.scalar = 32'h0; i.use_scalar = 1'b0; i.vm = 1'b1; i.mask = 64'h0;
        i.f6 = 6'h05; i.f3 = 3'h1; i.vl = 7'd16; i.tkt = 5'd1; i.rdc = 1'b0;
        return i;
    endfunction

    // Expected micro-ops of one instruction, straight from the split rules.
    task automatic push_expected(input ins_t ins);
        int n;
        n = (int'(ins.vl) + 7) / 8;
        if (n == 0) n = 1;
        for (int i = 0; i < n; i++) begin
            exp_t        e;
            logic [4:0]  a, b;
            logic [63:0] m;
            a = 5'(int'(ins.src1) + i);
            b = 5'(int'(ins.src2) + i);
            e.d1 = rf_mem[a];
            e.d2 = ins.use_scalar ? {8{ins.scalar}} : rf_mem[b];
            e.lv = 8'h00;
            e.lm = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (i * 8 + k < int'(ins.vl)) e.lv |= 8'(1) << k;
                m = ins.mask >> (i * 8 + k);
                if (ins.vm || m[0]) e.lm |= 8'(1) << k;
            end
            e.dst  = 5'(int'(ins.dst) + i);
            e.head = (i == 0);
            e.last = (i == n - 1);
            e.info = {ins.tkt, ins.f6, ins.f3, ins.vl, ins.rdc};
            expq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o) begin
            vectors++;
            assert (expq.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_uop: observed valid_o=1 expected no pending micro-op");
            end
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("data1", data1_o, mon_e.d1);
                chk("data2", data2_o, mon_e.d2);
                chk("lane_valid", lane_valid_o, mon_e.lv);
                chk("lane_mask", lane_mask_o, mon_e.lm);
                chk("uop_dst", uop_dst_o, mon_e.dst);
                chk("head_end", {head_uop_o, end_uop_o}, {mon_e.head, mon_e.last});
                chk("info", {uop_ticket_o, uop_funct6_o, uop_funct3_o, uop_vl_o, uop_is_rdc_o}, mon_e.info);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        hold_i = ($urandom_range(0, 99) < hold_pct);
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input ins_t ins);
        bit acc;
        bit rdy;
        acc = 1'b0;
        dst_i = ins.dst; src1_i = ins.src1; src2_i = ins.src2;
        scalar_i = ins.scalar; use_scalar_i = ins.use_scalar; vm_i = ins.vm;
        mask_bits_i = ins.mask; funct6_i = ins.f6; funct3_i = ins.f3;
        vl_i = ins.vl; ticket_i = ins.tkt; is_rdc_i = ins.rdc;
        instr_valid_i = 1'b1;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            rdy = instr_ready_o;
            @(posedge clk);
            if (rdy) begin
                acc = 1'b1;
                push_expected(ins);
            end
            #1;
            hold_i = ($urandom_range(0, 99) < hold_pct);
        end
        instr_valid_i = 1'b0;
        chk("accept_in_time", acc, 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((expq.size() != 0 || !idle_o) && c < 400) begin
            tick();
            c++;
        end
        chk("drain_pending", expq.size(), 0);
    endtask

    initial begin
        ins_t ins, insb;
        for (int r = 0; r < 32; r++)
            rf_mem[r] = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        rst = 1'b1; hold_i = 1'b0; instr_valid_i = 1'b0;
        dst_i = '0; src1_i = '0; src2_i = '0; scalar_i = '0; use_scalar_i = 1'b0;
        vm_i = 1'b0; mask_bits_i = '0; funct6_i = '0; funct3_i = '0; vl_i = '0;
        ticket_i = '0; is_rdc_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_lane_valid", lane_valid_o, 0);
        chk("rst_head_end", {head_uop_o, end_uop_o}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two micro-ops, first valid one edge after accept, consecutive.
        ins = def_ins();
        send(ins);
        @(negedge clk);
        chk("lat_no_valid_yet", valid_o, 0);
        chk("rf_addr_a_idx0", rf_addr_a_o, 4);
        chk("rf_addr_b_idx0", rf_addr_b_o, 8);
        @(negedge clk);
        chk("lat_first_valid", valid_o, 1);
        chk("rf_addr_a_idx1", rf_addr_a_o, 5);
        @(negedge clk);
        chk("second_consecutive", valid_o, 1);
        drain();

        // Partial last micro-op.
        ins = def_ins(); ins.vl = 7'd11; ins.tkt = 5'd2;
        send(ins);
        drain();

        // vl==0 still yields one micro-op.
        ins = def_ins(); ins.vl = 7'd0; ins.tkt = 5'd3;
        send(ins);
        drain();
        chk("ready_after_vl0", instr_ready_o, 1);

        // Masked, scalar operand.
        ins = def_ins(); ins.vm = 1'b0; ins.mask = 64'hA5A5;
        ins.use_scalar = 1'b1; ins.scalar = 32'hDEADBEEF; ins.tkt = 5'd4; ins.rdc = 1'b1;
        send(ins);
        drain();

        // Hold for two cycles after the first micro-op, then a queued
        // instruction taken on the last micro-op cycle.
        ins = def_ins(); ins.vl = 7'd32; ins.tkt = 5'd5;
        send(ins);
        @(posedge clk); #1; hold_i = 1'b1;
        @(negedge clk);
        chk("hold_uop0_valid", valid_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_gap1", valid_o, 0);
        @(posedge clk); #1; hold_i = 1'b0;
        @(negedge clk);
        chk("hold_gap2", valid_o, 0);
        insb = def_ins(); insb.vl = 7'd8; insb.tkt = 5'd6; insb.src1 = 5'd20;
        send(insb);
        @(negedge clk);
        chk("b2b_prev_end", {valid_o, end_uop_o}, 2'b11);
        @(negedge clk);
        chk("b2b_next_head", {valid_o, head_uop_o}, 2'b11);
        drain();

        // Register address wrap-around.
        ins = def_ins(); ins.src1 = 5'd30; ins.vl = 7'd32; ins.tkt = 5'd7;
        send(ins);
        @(negedge clk); chk("wrap_addr0", rf_addr_a_o, 30);
        @(negedge clk); chk("wrap_addr1", rf_addr_a_o, 31);
        @(negedge clk); chk("wrap_addr2", rf_addr_a_o, 0);
        @(negedge clk); chk("wrap_addr3", rf_addr_a_o, 1);
        drain();

        // Reset in the middle of an instruction.
        ins = def_ins(); ins.vl = 7'd64; ins.tkt = 5'd8;
        send(ins);
        tick();
        tick();
        rst = 1'b1;
        @(posedge clk); #1;
        expq.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_idle", idle_o, 1);
        chk("midrst_ready", instr_ready_o, 1);
        @(posedge clk); #1;

        // Random instructions with random scoreboard holds.
        hold_pct = 25;
        for (int t = 0; t < 40; t++) begin
            ins.dst = 5'($urandom); ins.src1 = 5'($urandom); ins.src2 = 5'($urandom);
            ins.scalar = $urandom; ins.use_scalar = 1'($urandom);
            ins.vm = 1'($urandom); ins.mask = {$urandom, $urandom};
            ins.f6 = 6'($urandom); ins.f3 = 3'($urandom);
            ins.vl = 7'($urandom_range(0, 64)); ins.tkt = 5'($urandom);
            ins.rdc = 1'($urandom);
            send(ins);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) tick();
        end
        drain();
        hold_pct = 0;
        tick();
        chk("final_idle", idle_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
